// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the two-requester memory arbiter.
// No logic beyond constants, a request record and one helper.
// Imported by mem_arbiter and rr_arb2.
package mem_arbiter_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    // FSM states, kept as plain constants so the encoding stays fixed.
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SERVE_IC = 2'd1;
    localparam logic [1:0] S_SERVE_DC = 2'd2;

    // Requester identifiers, also the encoding of last_grant.
    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    // One downstream line request as it is issued to memory.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

    // Build the issued request; read+write together collapses to a write.
    function automatic mem_req_t issue_req(
        input logic              rd,
        input logic              wr,
        input logic [ADDR_W-1:0] addr,
        input logic [LINE_W-1:0] wdata
    );
        mem_req_t r;
        r.rd    = rd & ~wr;
        r.wr    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant_id
);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_vld = req_ic | req_dc;
        if (req_ic && req_dc) begin
            grant_id = ~last_grant;
        end else if (req_dc) begin
            grant_id = REQ_DC;
        end else begin
            grant_id = REQ_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache.
// Latency: request cycle N -> mem_read/mem_write at N+1; ready forwarded in the mem_ready cycle.
// Backpressure: requesters hold until their ready; one idle cycle separates transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_mem_read,
    input  logic              ic_mem_write,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    input  logic [LINE_W-1:0] ic_mem_wdata,
    output logic              ic_mem_ready,
    output logic [LINE_W-1:0] ic_mem_rdata,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [LINE_W-1:0] dc_mem_wdata,
    output logic              dc_mem_ready,
    output logic [LINE_W-1:0] dc_mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       ic_txn_counter,
    output logic [31:0]       dc_txn_counter
);

    logic [1:0]  state, state_nxt;
    logic        last_grant, last_grant_nxt;
    mem_req_t    req_q, req_nxt, sel_req;
    logic [31:0] ic_cnt_nxt, dc_cnt_nxt;
    logic        grant_vld, grant_id;

    rr_arb2 u_rr_arb2 (
        .req_ic     (ic_mem_read | ic_mem_write),
        .req_dc     (dc_mem_read | dc_mem_write),
        .last_grant (last_grant),
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    assign mem_read  = req_q.rd;
    assign mem_write = req_q.wr;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    // Next-state, request capture, counters and ready forwarding.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        req_nxt        = req_q;
        ic_cnt_nxt     = ic_txn_counter;
        dc_cnt_nxt     = dc_txn_counter;
        ic_mem_ready   = 1'b0;
        dc_mem_ready   = 1'b0;
        ic_mem_rdata   = mem_rdata;
        dc_mem_rdata   = mem_rdata;
        sel_req        = (grant_id == REQ_DC)
                       ? issue_req(dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata)
                       : issue_req(ic_mem_read, ic_mem_write, ic_mem_addr, ic_mem_wdata);

        case (state)
            S_IDLE: begin
                // mem_ready here belongs to nobody and is dropped.
                if (grant_vld) begin
                    last_grant_nxt = grant_id;
                    req_nxt        = sel_req;
                    if (grant_id == REQ_DC) begin
                        state_nxt  = S_SERVE_DC;
                        dc_cnt_nxt = dc_txn_counter + 32'd1;
                    end else begin
                        state_nxt  = S_SERVE_IC;
                        ic_cnt_nxt = ic_txn_counter + 32'd1;
                    end
                end
            end
            S_SERVE_IC: begin
                ic_mem_ready = mem_ready;
                if (mem_ready) begin
                    state_nxt  = S_IDLE;
                    req_nxt.rd = 1'b0;
                    req_nxt.wr = 1'b0;
                end
            end
            S_SERVE_DC: begin
                dc_mem_ready = mem_ready;
                if (mem_ready) begin
                    state_nxt  = S_IDLE;
                    req_nxt.rd = 1'b0;
                    req_nxt.wr = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state          <= S_IDLE;
            last_grant     <= REQ_IC;
            req_q          <= '0;
            ic_txn_counter <= '0;
            dc_txn_counter <= '0;
        end else begin
            state          <= state_nxt;
            last_grant     <= last_grant_nxt;
            req_q          <= req_nxt;
            ic_txn_counter <= ic_cnt_nxt;
            dc_txn_counter <= dc_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a transaction-level model of the arbiter.
// Directed steps also compare against hand-derived constants.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              ic_mem_read, ic_mem_write, dc_mem_read, dc_mem_write;
    logic [ADDR_W-1:0] ic_mem_addr, dc_mem_addr, mem_addr;
    logic [LINE_W-1:0] ic_mem_wdata, dc_mem_wdata, mem_wdata;
    logic [LINE_W-1:0] ic_mem_rdata, dc_mem_rdata, mem_rdata;
    logic              ic_mem_ready, dc_mem_ready, mem_read, mem_write, mem_ready;
    logic [31:0]       ic_txn_counter, dc_txn_counter;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner of the port (or none), last winner, issued request, counts.
    bit              m_busy;
    bit              m_who;
    bit              m_last;
    bit              m_rd, m_wr;
    bit [ADDR_W-1:0] m_addr;
    bit [LINE_W-1:0] m_wdata;
    bit [31:0]       m_cnt [2];

    mem_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .ic_mem_read(ic_mem_read), .ic_mem_write(ic_mem_write),
        .ic_mem_addr(ic_mem_addr), .ic_mem_wdata(ic_mem_wdata),
        .ic_mem_ready(ic_mem_ready), .ic_mem_rdata(ic_mem_rdata),
        .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_mem_ready(dc_mem_ready), .dc_mem_rdata(dc_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ic_txn_counter(ic_txn_counter), .dc_txn_counter(dc_txn_counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_who = 0; m_last = 0;
        m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit pi, pd;
        if (proc_reset) begin
            model_reset();
        end else if (!m_busy) begin
            pi = ic_mem_read | ic_mem_write;
            pd = dc_mem_read | dc_mem_write;
            if (pi || pd) begin
                m_who  = (pi && pd) ? ~m_last : pd;
                m_last = m_who;
                m_busy = 1;
                m_cnt[m_who] = m_cnt[m_who] + 1;
                if (m_who) begin
                    m_wr = dc_mem_write; m_rd = dc_mem_read && !dc_mem_write;
                    m_addr = dc_mem_addr; m_wdata = dc_mem_wdata;
                end else begin
                    m_wr = ic_mem_write; m_rd = ic_mem_read && !ic_mem_write;
                    m_addr = ic_mem_addr; m_wdata = ic_mem_wdata;
                end
            end
        end else if (mem_ready) begin
            m_busy = 0; m_rd = 0; m_wr = 0;
        end
    endtask

    task automatic check_comb();
        chk("ic_ready", ic_mem_ready, m_busy && !m_who && mem_ready);
        chk("dc_ready", dc_mem_ready, m_busy &&  m_who && mem_ready);
        chk("ic_rdata", ic_mem_rdata, mem_rdata);
        chk("dc_rdata", dc_mem_rdata, mem_rdata);
    endtask

    task automatic check_regs();
        chk("mem_read",  mem_read,  m_rd);
        chk("mem_write", mem_write, m_wr);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("ic_cnt",    ic_txn_counter, m_cnt[0]);
        chk("dc_cnt",    dc_txn_counter, m_cnt[1]);
    endtask

    // One clock: check outputs of the current cycle, clock, check registered outputs.
    task automatic tick();
        #1 check_comb();
        model_step();
        @(posedge clk);
        #1 check_regs();
    endtask

    initial begin
        logic [LINE_W-1:0] aa;
        aa = {16{8'hAA}};
        proc_reset = 1; mem_ready = 0; mem_rdata = '0;
        ic_mem_read = 0; ic_mem_write = 0; ic_mem_addr = '0; ic_mem_wdata = '0;
        dc_mem_read = 0; dc_mem_write = 0; dc_mem_addr = '0; dc_mem_wdata = '0;
        model_reset();
        @(posedge clk); #1;
        tick();
        chk("rst_read", mem_read, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ic_cnt", ic_txn_counter, 0);
        proc_reset = 0;

        // Single D-cache read, mem_ready in cycle 5.
        dc_mem_read = 1; dc_mem_addr = 28'h0000010; mem_rdata = {4{32'h1234_5678}};
        tick();
        for (int c = 2; c <= 4; c++) begin
            chk("rd_busy", mem_read, 1);
            chk("rd_addr", mem_addr, 28'h10);
            #1 chk("rd_noready", dc_mem_ready, 0);
            tick();
        end
        chk("rd_c5", mem_read, 1);
        mem_ready = 1;
        #1 chk("rd_ready", dc_mem_ready, 1);
        chk("rd_rdata", dc_mem_rdata, {4{32'h1234_5678}});
        tick();
        mem_ready = 0; dc_mem_read = 0;
        chk("rd_done", mem_read, 0);
        chk("rd_cnt", dc_txn_counter, 1);

        // Tie after reset goes to DC, then IC after one idle cycle.
        proc_reset = 1; tick(); proc_reset = 0;
        ic_mem_read = 1; ic_mem_addr = 28'h1;
        dc_mem_read = 1; dc_mem_addr = 28'h2;
        tick();
        chk("tie_dc_first", mem_addr, 28'h2);
        mem_ready = 1;
        #1 chk("tie_dc_ready", dc_mem_ready, 1);
        tick();
        dc_mem_read = 0; mem_ready = 0;
        chk("tie_idle", mem_read, 0);
        tick();
        chk("tie_ic_addr", mem_addr, 28'h1);
        chk("tie_ic_read", mem_read, 1);
        mem_ready = 1; tick();
        ic_mem_read = 0; mem_ready = 0;

        // Fairness: both held for six transactions.
        proc_reset = 1; tick(); proc_reset = 0;
        ic_mem_read = 1; ic_mem_addr = 28'h100;
        dc_mem_read = 1; dc_mem_addr = 28'h200;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fair_grant", mem_addr, (i % 2 == 0) ? 28'h200 : 28'h100);
            mem_ready = 1; tick(); mem_ready = 0;
        end
        chk("fair_ic_cnt", ic_txn_counter, 3);
        chk("fair_dc_cnt", dc_txn_counter, 3);
        ic_mem_read = 0; dc_mem_read = 0;

        // Write-back then refill from the D-cache.
        dc_mem_write = 1; dc_mem_addr = 28'h3; dc_mem_wdata = aa;
        tick();
        chk("wb_write", mem_write, 1);
        chk("wb_wdata", mem_wdata, aa);
        mem_ready = 1;
        #1 chk("wb_ic_quiet", ic_mem_ready, 0);
        tick();
        mem_ready = 0; dc_mem_write = 0; dc_mem_read = 1; dc_mem_addr = 28'h7;
        chk("wb_idle", mem_write, 0);
        tick();
        chk("rf_read", mem_read, 1);
        chk("rf_addr", mem_addr, 28'h7);
        mem_ready = 1; tick();
        dc_mem_read = 0; mem_ready = 0;

        // mem_ready in idle is ignored; reset mid-IC-transaction discards it.
        mem_ready = 1;
        #1 chk("ign_ic", ic_mem_ready, 0);
        chk("ign_dc", dc_mem_ready, 0);
        tick();
        chk("ign_state", mem_read, 0);
        mem_ready = 0; ic_mem_read = 1; ic_mem_addr = 28'h9;
        tick();
        chk("ab_busy", mem_read, 1);
        ic_mem_read = 0; proc_reset = 1;
        tick();
        chk("ab_read", mem_read, 0);
        chk("ab_cnt", ic_txn_counter, 0);
        proc_reset = 0; mem_ready = 1;
        #1 chk("ab_noready", ic_mem_ready, 0);
        tick();
        mem_ready = 0;

        // Read and write together issue a write only.
        ic_mem_read = 1; ic_mem_write = 1; ic_mem_addr = 28'h5;
        tick();
        chk("rw_write", mem_write, 1);
        chk("rw_read", mem_read, 0);
        mem_ready = 1; tick();
        ic_mem_read = 0; ic_mem_write = 0; mem_ready = 0;

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            proc_reset   = ($urandom_range(0, 99) == 0);
            ic_mem_read  = 1'($urandom_range(0, 1));
            ic_mem_write = ($urandom_range(0, 3) == 0);
            dc_mem_read  = 1'($urandom_range(0, 1));
            dc_mem_write = ($urandom_range(0, 3) == 0);
            ic_mem_addr  = 28'($urandom);
            dc_mem_addr  = 28'($urandom);
            ic_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            dc_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata    = {$urandom, $urandom, $urandom, $urandom};
            mem_ready    = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
